// File: rtl/serial_adder.sv
// Bit-serial adder: {C_out, Sum} = A + B + C_in, one bit per clock, LSB first,
// built around a single full_adder cell with a registered carry between steps.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic Sum,
  output logic C_out
);

  assign Sum   = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

module serial_adder_chk (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic done
);

  // done and busy are never high together
  assert property (@(posedge clk) disable iff (rst) done |-> !busy)
    else $error("serial_adder_chk: done asserted while busy");

  // done is a single-cycle pulse
  assert property (@(posedge clk) disable iff (rst) done |=> !done)
    else $error("serial_adder_chk: done held longer than one cycle");

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-2:0] result_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             busy_r;
  logic             done_r;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_next_s;

  full_adder u_fa (
    .A     (a_sh_r[0]),
    .B     (b_sh_r[0]),
    .C_in  (carry_r),
    .Sum   (fa_sum_s),
    .C_out (fa_cout_s)
  );

  // Newest sum bit enters at the MSB; after WIDTH steps bit 0 lands at position 0
  assign res_next_s = {fa_sum_s, result_r};

  // Next-state and step control
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand shifters, carry, bit counter and partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= CNT_ZERO;
      result_r <= {(WIDTH-1){1'b0}};
    end else if (load_s) begin
      a_sh_r   <= A;
      b_sh_r   <= B;
      carry_r  <= C_in;
      cnt_r    <= CNT_ZERO;
    end else if (step_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      carry_r  <= fa_cout_s;
      cnt_r    <= cnt_r + CNT_ONE;
      result_r <= res_next_s[WIDTH-1:1];
    end
  end

  // Visible result only updates when the last bit is processed
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
    end else if (last_s) begin
      sum_r   <= res_next_s;
      c_out_r <= fa_cout_s;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign Sum   = sum_r;
  assign C_out = c_out_r;

  serial_adder_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .done (done)
  );

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random
// operands compared against a plain-arithmetic reference.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_in;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         C_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Present operands with start for one edge, then scramble the operand pins
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string tag);
    A = a; B = b; C_in = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); C_in = 1'($urandom);
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check({tag, "_accept_done"}, 32'(done), 32'd0);
  endtask

  // Walk through the remaining RUN cycles and check the done cycle
  task automatic finish_op(input logic [W:0] expv, input int poke_at, input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i < W; i++) begin
      if (i == poke_at) begin
        start = 1'b1; A = 8'h01; B = 8'h01; C_in = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0 || Sum !== prev_sum || C_out !== prev_cout) bad++;
    end
    check({tag, "_run"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(Sum), 32'(expv[W-1:0]));
    check({tag, "_cout"}, 32'(C_out), 32'(expv[W]));
    prev_sum  = expv[W-1:0];
    prev_cout = expv[W];
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_sum"}, 32'(Sum), 32'(prev_sum));
  endtask

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string tag);
    start_op(a, b, cin, tag);
    finish_op(model(a, b, cin), 0, tag);
    idle_check(tag);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           dcount;

    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; C_in = 1'b0;
    prev_sum = 8'h00; prev_cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(Sum), 32'd0);
    check("reset_cout", 32'(C_out), 32'd0);

    // start while in reset is ignored
    start = 1'b1; A = 8'h11; B = 8'h22;
    @(posedge clk); #1;
    check("rst_start_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // first edge with rst low and start high is accepted
    start_op(8'h00, 8'h00, 1'b0, "zero");
    finish_op(model(8'h00, 8'h00, 1'b0), 0, "zero");
    idle_check("zero");

    add(8'hFF, 8'h01, 1'b0, "ff_01");
    add(8'h7F, 8'h01, 1'b0, "7f_01");
    add(8'hA5, 8'h5A, 1'b1, "a5_5a");

    // start pulsed mid-run is ignored and not queued
    start_op(8'h10, 8'h20, 1'b0, "ignore");
    finish_op(model(8'h10, 8'h20, 1'b0), 3, "ignore");
    idle_check("ignore");

    // reset during the 4th RUN cycle aborts without done
    start_op(8'h33, 8'h44, 1'b0, "abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(Sum), 32'd0);
    check("abort_cout", 32'(C_out), 32'd0);
    prev_sum = 8'h00; prev_cout = 1'b0;
    dcount = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    add(8'h12, 8'h34, 1'b1, "post_abort");

    // back-to-back: start held during the DONE cycle
    start_op(8'h55, 8'h66, 1'b0, "b2b_first");
    finish_op(model(8'h55, 8'h66, 1'b0), 0, "b2b_first");
    start_op(8'h03, 8'h04, 1'b0, "b2b_second");
    finish_op(model(8'h03, 8'h04, 1'b0), 0, "b2b_second");
    idle_check("b2b");

    // random operands, randomly back-to-back
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      start_op(ra, rb, rc, "rand");
      finish_op(model(ra, rb, rc), int'($urandom_range(0, 9)), "rand");
      if ($urandom_range(0, 1) == 1 || n == 23) idle_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
